// File: rtl/rgb_fade_ctrl.sv
// RGB LED colour controller: accepts colour/fade commands, ramps each channel
// linearly toward its target, and drives one registered PWM bit per channel.
module rgb_fade_ctrl #(
  parameter int PWM_BITS = 8,
  parameter int STEP_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [PWM_BITS-1:0] cmd_r,
  input  logic [PWM_BITS-1:0] cmd_g,
  input  logic [PWM_BITS-1:0] cmd_b,
  input  logic [STEP_W-1:0]   cmd_step,
  input  logic                abort,
  output logic                busy,
  output logic [PWM_BITS-1:0] cur_r,
  output logic [PWM_BITS-1:0] cur_g,
  output logic [PWM_BITS-1:0] cur_b,
  output logic                pwm_r,
  output logic                pwm_g,
  output logic                pwm_b
);

  typedef enum logic {IDLE, FADE} state_t;

  state_t                         state_reg, state_next;
  logic [2:0][PWM_BITS-1:0]       cur_reg, cur_next;
  logic [2:0][PWM_BITS-1:0]       tgt_reg, tgt_next;
  logic [2:0][PWM_BITS-1:0]       stepped;
  logic [2:0][PWM_BITS-1:0]       cmd_vec;
  logic [STEP_W-1:0]              step_reg, step_next;
  logic [STEP_W-1:0]              presc_reg, presc_next;
  logic [PWM_BITS-1:0]            pwm_cnt_reg;
  logic [2:0]                     pwm_reg;

  assign cmd_vec   = {cmd_b, cmd_g, cmd_r};
  assign cmd_ready = (state_reg == IDLE) && !abort && !rst;
  assign busy      = (state_reg == FADE);

  // Channels move one LSB toward their target, so they can never wrap.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign stepped[gi] = (cur_reg[gi] < tgt_reg[gi]) ? cur_reg[gi] + 1'b1 :
                         (cur_reg[gi] > tgt_reg[gi]) ? cur_reg[gi] - 1'b1 :
                                                       cur_reg[gi];

    always_ff @(posedge clk) begin
      if (rst) begin
        pwm_reg[gi] <= 1'b0;
      end else begin
        pwm_reg[gi] <= (pwm_cnt_reg < cur_reg[gi]);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    tgt_next   = tgt_reg;
    step_next  = step_reg;
    presc_next = presc_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_step == '0) begin
            cur_next = cmd_vec;
          end else begin
            tgt_next   = cmd_vec;
            step_next  = cmd_step;
            presc_next = '0;
            state_next = FADE;
          end
        end
      end
      FADE: begin
        // Abort wins over a due step: intensities freeze at their pre-edge value.
        if (abort) begin
          state_next = IDLE;
        end else if (presc_reg == step_reg - 1'b1) begin
          presc_next = '0;
          cur_next   = stepped;
          if (stepped == tgt_reg) begin
            state_next = IDLE;
          end
        end else begin
          presc_next = presc_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cur_reg     <= '0;
      tgt_reg     <= '0;
      step_reg    <= '0;
      presc_reg   <= '0;
      pwm_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cur_reg     <= cur_next;
      tgt_reg     <= tgt_next;
      step_reg    <= step_next;
      presc_reg   <= presc_next;
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
    end
  end

  assign cur_r = cur_reg[0];
  assign cur_g = cur_reg[1];
  assign cur_b = cur_reg[2];
  assign pwm_r = pwm_reg[0];
  assign pwm_g = pwm_reg[1];
  assign pwm_b = pwm_reg[2];

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Bench for rgb_fade_ctrl: per-cycle comparison against an arithmetic model,
// a table of command vectors, directed corner-case sequences and random traffic.
module tb_rgb_fade_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_r, cmd_g, cmd_b;
  logic [15:0] cmd_step;
  logic        abort;
  logic        busy;
  logic [7:0]  cur_r, cur_g, cur_b;
  logic        pwm_r, pwm_g, pwm_b;

  always #5 clk = ~clk;

  rgb_fade_ctrl #(.PWM_BITS(8), .STEP_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_r(cmd_r), .cmd_g(cmd_g), .cmd_b(cmd_b), .cmd_step(cmd_step),
    .abort(abort), .busy(busy), .cur_r(cur_r), .cur_g(cur_g), .cur_b(cur_b),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b)
  );

  int total = 0;
  int bad   = 0;

  // Model: fade progress is tracked as cycles elapsed since acceptance;
  // a step is due whenever that age is a multiple of the step length.
  int m_cur[3] = '{0, 0, 0};
  int m_tgt[3] = '{0, 0, 0};
  int m_s = 0, m_age = 0, m_cnt = 0;
  bit m_fade = 1'b0;
  bit m_pwm[3] = '{1'b0, 1'b0, 1'b0};

  typedef struct {
    int r, g, b, s, wait_cyc, er, eg, eb;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pack3(input int r, input int g, input int b);
    return r | (g << 8) | (b << 16);
  endfunction

  function automatic int m_ready();
    return (!m_fade && !abort && !rst) ? 1 : 0;
  endfunction

  task automatic model_edge();
    int  cmdv[3];
    int  rdy;
    bit  all_eq;
    cmdv = '{int'(cmd_r), int'(cmd_g), int'(cmd_b)};
    rdy  = m_ready();
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_cur[i] = 0; m_tgt[i] = 0; m_pwm[i] = 1'b0;
      end
      m_cnt = 0; m_fade = 1'b0; m_age = 0; m_s = 0;
    end else begin
      for (int i = 0; i < 3; i++) m_pwm[i] = (m_cnt < m_cur[i]);
      m_cnt = (m_cnt + 1) % 256;
      if (m_fade) begin
        if (abort) begin
          m_fade = 1'b0;
        end else begin
          m_age++;
          if (m_age % m_s == 0) begin
            all_eq = 1'b1;
            for (int i = 0; i < 3; i++) begin
              if (m_cur[i] < m_tgt[i]) m_cur[i]++;
              else if (m_cur[i] > m_tgt[i]) m_cur[i]--;
              if (m_cur[i] != m_tgt[i]) all_eq = 1'b0;
            end
            if (all_eq) m_fade = 1'b0;
          end
        end
      end else if (rdy != 0 && cmd_valid) begin
        if (cmd_step == 0) begin
          for (int i = 0; i < 3; i++) m_cur[i] = cmdv[i];
        end else begin
          for (int i = 0; i < 3; i++) m_tgt[i] = cmdv[i];
          m_s = int'(cmd_step); m_age = 0; m_fade = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle();
    #1;
    chk("ready", int'(cmd_ready), m_ready());
    @(posedge clk);
    model_edge();
    #1;
    chk("busy", int'(busy), int'(m_fade));
    chk("cur", int'({cur_b, cur_g, cur_r}), pack3(m_cur[0], m_cur[1], m_cur[2]));
    chk("pwm", int'({pwm_b, pwm_g, pwm_r}), int'({m_pwm[2], m_pwm[1], m_pwm[0]}));
  endtask

  task automatic send(input int r, input int g, input int b, input int s);
    cmd_r = 8'(r); cmd_g = 8'(g); cmd_b = 8'(b); cmd_step = 16'(s);
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
  endtask

  // Counts cycles with busy high; records g at the first cycle r reaches 5.
  task automatic run_fade(output int nbusy, output int g_at_r5);
    bit done = 1'b0;
    bit seen = 1'b0;
    nbusy = 0; g_at_r5 = -1;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (busy) begin
        nbusy++;
        cycle();
        if (!seen && cur_r == 8'd5) begin
          seen = 1'b1; g_at_r5 = int'(cur_g);
        end
      end else begin
        done = 1'b1;
      end
    end
    if (!done) chk("fade_timeout", 0, 1);
  endtask

  initial begin
    int hr, hg, hb, nb, g5, busy_seen;
    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_r = '0; cmd_g = '0; cmd_b = '0; cmd_step = '0;

    vecs[0] = '{20, 30, 40, 0, 0, 20, 30, 40};
    vecs[1] = '{22, 28, 40, 2, 4, 22, 28, 40};
    vecs[2] = '{22, 28, 40, 5, 5, 22, 28, 40};
    vecs[3] = '{0, 255, 41, 1, 227, 0, 255, 41};
    vecs[4] = '{255, 0, 0, 0, 0, 255, 0, 0};
    vecs[5] = '{250, 5, 3, 3, 15, 250, 5, 3};

    // Reset, then idle for 1024 cycles: everything dark.
    repeat (3) cycle();
    rst = 1'b0;
    hr = 0; hg = 0; hb = 0;
    for (int i = 0; i < 1024; i++) begin
      cycle();
      hr += int'(pwm_r); hg += int'(pwm_g); hb += int'(pwm_b);
    end
    chk("idle_pwm_highs", hr + hg + hb, 0);
    chk("idle_cur", int'({cur_b, cur_g, cur_r}), 0);

    // Immediate jump and PWM duty over one full period.
    send(255, 128, 0, 0);
    chk("jump_cur", int'({cur_b, cur_g, cur_r}), pack3(255, 128, 0));
    cycle();
    hr = 0; hg = 0; hb = 0; busy_seen = 0;
    for (int i = 0; i < 256; i++) begin
      cycle();
      hr += int'(pwm_r); hg += int'(pwm_g); hb += int'(pwm_b);
      busy_seen += int'(busy);
    end
    chk("duty_r", hr, 255);
    chk("duty_g", hg, 128);
    chk("duty_b", hb, 0);
    chk("jump_busy", busy_seen, 0);

    // Table of command vectors.
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].r, vecs[v].g, vecs[v].b, vecs[v].s);
      if (vecs[v].wait_cyc > 0) begin
        repeat (vecs[v].wait_cyc - 1) cycle();
        chk("vec_busy_last", int'(busy), 1);
        cycle();
      end
      chk("vec_cur", int'({cur_b, cur_g, cur_r}), pack3(vecs[v].er, vecs[v].eg, vecs[v].eb));
      chk("vec_busy_end", int'(busy), 0);
    end

    // Fade 0 -> (10,4,0) step 3, with a new command held during the fade.
    send(0, 0, 0, 0);
    send(10, 4, 0, 3);
    cmd_r = 8'd1; cmd_g = 8'd2; cmd_b = 8'd3; cmd_step = 16'd0; cmd_valid = 1'b1;
    run_fade(nb, g5);
    chk("fade_busy_len", nb, 30);
    chk("fade_g_stop", g5, 4);
    chk("fade_r_final", int'(cur_r), 10);
    cycle();
    cmd_valid = 1'b0;
    chk("held_cmd", int'({cur_b, cur_g, cur_r}), pack3(1, 2, 3));

    // Down/up fade at step 1.
    send(200, 200, 200, 0);
    send(195, 200, 205, 1);
    run_fade(nb, g5);
    chk("down_busy_len", nb, 5);
    chk("down_cur", int'({cur_b, cur_g, cur_r}), pack3(195, 200, 205));

    // Abort on the edge where the third step is due.
    send(0, 0, 0, 0);
    send(50, 50, 50, 4);
    repeat (11) cycle();
    chk("pre_abort_r", int'(cur_r), 2);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_cur", int'({cur_b, cur_g, cur_r}), pack3(2, 2, 2));
    chk("abort_busy", int'(busy), 0);
    repeat (20) cycle();
    chk("abort_frozen", int'({cur_b, cur_g, cur_r}), pack3(2, 2, 2));

    // Reset in the middle of a fade.
    send(100, 100, 100, 2);
    repeat (20) cycle();
    rst = 1'b1;
    cycle();
    chk("rst_cur", int'({cur_b, cur_g, cur_r}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pwm", int'({pwm_b, pwm_g, pwm_r}), 0);
    rst = 1'b0;
    send(7, 8, 9, 0);
    chk("post_rst_jump", int'({cur_b, cur_g, cur_r}), pack3(7, 8, 9));

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      abort     = ($urandom_range(0, 15) == 0);
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_r     = 8'($urandom);
      cmd_g     = 8'($urandom);
      cmd_b     = 8'($urandom);
      cmd_step  = 16'($urandom_range(0, 3));
      cycle();
    end
    rst = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
